multi_button_conditioner: RTL and testbench
===========================================

# multi_button_conditioner

Parametrised front end for the board's active-low push buttons (Run, Continue and similar) feeding the processor control logic. Each of NUM_BTNS channels is synchronised, debounced and converted into a clean level plus single-cycle press, release and auto-repeat pulses. Per-channel auto-repeat lets a held Continue button step the processor repeatedly without re-pressing.

## Interface
- NUM_BTNS, 4: number of independent button channels
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed to accept a change (≥1)
- REPEAT_DELAY, 64: cycles from press_pulse to first repeat_pulse (≥1)
- REPEAT_PERIOD, 16: cycles between successive repeat_pulse (≥1)

- Clk  in  1  system clock; all logic on its rising edge
- Reset  in  1  synchronous, active-high reset
- btn_n  in  NUM_BTNS  raw asynchronous buttons, active-low (0 = pressed)
- repeat_en  in  NUM_BTNS  per-channel auto-repeat enable, synchronous
- pressed  out  NUM_BTNS  debounced level, 1 = held
- press_pulse  out  NUM_BTNS  one-cycle pulse on accepted press
- release_pulse  out  NUM_BTNS  one-cycle pulse on accepted release
- repeat_pulse  out  NUM_BTNS  one-cycle auto-repeat pulse

## Operation
- Channels are fully independent; behaviour below is per channel.
- Synchroniser: SYNC_STAGES flops, all reset to 1 (released).
- Debounce: register `stable` (reset 1). Counter increments each cycle the synchroniser output ≠ stable and clears whenever they are equal. When the count reaches DEBOUNCE_CYCLES, stable takes the synchroniser value and the counter clears. Any glitch shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged.
- pressed = ~stable, registered.
- FSM states: IDLE, HELD, REPEAT.
  - IDLE -> HELD on accepted press; press_pulse = 1 that cycle. Hold counter is cleared.
  - HELD: hold counter counts while repeat_en = 1. When the count reaches REPEAT_DELAY: repeat_pulse, then go to REPEAT with the counter cleared. If repeat_en = 0, the counter is held at 0.
  - REPEAT: counter counts to REPEAT_PERIOD, then repeat_pulse and clear. If repeat_en drops, return to HELD with the counter cleared and no pulse.
  - Any state -> IDLE on accepted release; release_pulse = 1. No repeat_pulse is emitted in the release cycle, even if the counter expires that cycle.
- Counter widths: $clog2(param+1). No wrap-around is possible because counters always clear at the terminal value.

## Timing
- Reset: all outputs 0; synchroniser and stable = 1; counters 0; FSM in IDLE.
- Press latency: btn_n first sampled low at edge E0 -> pressed and press_pulse high after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES−1 (17 with defaults). Release latency is identical.
- press_pulse, release_pulse and repeat_pulse are each exactly 1 cycle wide. Pulse outputs and pressed are registered, with no combinational path from inputs.
- First repeat_pulse: REPEAT_DELAY cycles after press_pulse. Subsequent pulses: every REPEAT_PERIOD cycles.
- repeat_en is sampled each cycle, and a change takes effect the following cycle.
- Reset asserted mid-press: the next cycle shows reset values. If the button is still held after Reset deasserts, it is treated as a new press after the full latency, with a fresh press_pulse.

## Structure
- Package `button_pkg`:
  - state enum `btn_state_t` {IDLE, HELD, REPEAT}
  - default parameter constants
- Sub-module `button_channel`: one synchroniser, debouncer, FSM and counters for a single channel, instantiated NUM_BTNS times in a generate loop. The top level only slices the buses.

## Test plan
- Reset release with all btn_n = 1 -> all outputs 0 for 100 cycles.
- Channel 0 held low from edge E0 -> pressed[0] and press_pulse[0] high after edge E0+17; press_pulse is 1 cycle; other channels stay 0. Release -> release_pulse[0] 17 edges after the first high sample.
- 15-cycle low glitch, then high -> no output change. A 16-cycle low -> press accepted.
- repeat_en[1] = 1, hold channel 1 for 200 cycles -> repeat_pulse at +64, +80, +96 … cycles after press_pulse (9 pulses). Drop repeat_en at the 3rd pulse -> no further pulses; pressed stays 1.
- Channels 2 and 3 pressed 5 cycles apart with repeat enabled -> independent pulse trains offset by 5 cycles. Release on a repeat-expiry cycle -> release_pulse only.
- Reset asserted 30 cycles into a hold with btn_n still low -> outputs 0 next cycle; press_pulse re-fires 17 edges after Reset deasserts.

Source files
------------

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_pkg
// Purpose  : Shared state encoding, default parameters and helper for the
//            push-button conditioner.
// Revision : 1.0 - initial release
// ============================================================================
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int DEF_NUM_BTNS        = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 64;
    localparam int DEF_REPEAT_PERIOD   = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module   : button_channel
// Purpose  : One button: synchroniser, debouncer and press/repeat/release FSM.
// Revision : 1.0 - initial release
// ============================================================================
module button_channel
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_n,
    input  logic repeat_en,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;
    logic [DB_W-1:0]        r_db_cnt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    btn_state_t             r_state;

    logic w_sync_out;
    logic w_differ;
    logic w_accept;
    logic w_press_acc;
    logic w_rel_acc;

    // Acceptance is decided on the edge the count would reach its terminal
    // value, so the outputs land on the same edge as the new stable level.
    assign w_sync_out  = r_sync[SYNC_STAGES-1];
    assign w_differ    = (w_sync_out != r_stable);
    assign w_accept    = w_differ && (r_db_cnt == DB_LAST);
    assign w_press_acc = w_accept && r_stable;
    assign w_rel_acc   = w_accept && !r_stable;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_n};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stable <= 1'b1;
            r_db_cnt <= '0;
        end else if (w_accept) begin
            r_stable <= w_sync_out;
            r_db_cnt <= '0;
        end else if (!w_differ) begin
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_hold_cnt    <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            // Release wins over any repeat expiry in the same cycle.
            if (w_rel_acc) begin
                r_state       <= IDLE;
                r_hold_cnt    <= '0;
                pressed       <= 1'b0;
                release_pulse <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_press_acc) begin
                            r_state     <= HELD;
                            r_hold_cnt  <= '0;
                            pressed     <= 1'b1;
                            press_pulse <= 1'b1;
                        end
                    end
                    HELD: begin
                        if (!repeat_en) begin
                            r_hold_cnt <= '0;
                        end else if (r_hold_cnt == DELAY_LAST) begin
                            r_state      <= REPEAT;
                            r_hold_cnt   <= '0;
                            repeat_pulse <= 1'b1;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!repeat_en) begin
                            r_state    <= HELD;
                            r_hold_cnt <= '0;
                        end else if (r_hold_cnt == PERIOD_LAST) begin
                            r_hold_cnt   <= '0;
                            repeat_pulse <= 1'b1;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : multi_button_conditioner
// Purpose  : NUM_BTNS independent button channels sliced from shared buses.
// Revision : 1.0 - initial release
// ============================================================================
module multi_button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTNS        = DEF_NUM_BTNS,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_BTNS-1:0] btn_n,
    input  logic [NUM_BTNS-1:0] repeat_en,
    output logic [NUM_BTNS-1:0] pressed,
    output logic [NUM_BTNS-1:0] press_pulse,
    output logic [NUM_BTNS-1:0] release_pulse,
    output logic [NUM_BTNS-1:0] repeat_pulse
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        button_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .Clk           (Clk),
            .Reset         (Reset),
            .btn_n         (btn_n[i]),
            .repeat_en     (repeat_en[i]),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_button_conditioner
// Purpose  : Directed scoreboard bench for multi_button_conditioner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_button_conditioner;

    localparam int N   = 4;
    localparam int LAT = 2 + 16 - 1;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_REP   = 2;
    localparam int K_CLR   = 3;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } ev_t;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [N-1:0] btn_n;
    logic [N-1:0] repeat_en;
    logic [N-1:0] pressed;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] repeat_pulse;

    int     cyc = 0;
    int     compared = 0;
    int     mismatched = 0;
    bit     mon_en = 1'b0;
    ev_t    sb[$];
    logic [N-1:0] exp_pressed = '0;
    logic [N-1:0] e_press, e_rel, e_rep;

    multi_button_conditioner dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .btn_n         (btn_n),
        .repeat_en     (repeat_en),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic push(input int c, input int k, input int ch);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.ch   = ch;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    // Pops every event due this cycle and compares all four output buses.
    always @(negedge Clk) begin
        if (mon_en) begin
            e_press = '0;
            e_rel   = '0;
            e_rep   = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    case (sb[i].kind)
                        K_PRESS: begin e_press[sb[i].ch] = 1'b1; exp_pressed[sb[i].ch] = 1'b1; end
                        K_REL:   begin e_rel[sb[i].ch]   = 1'b1; exp_pressed[sb[i].ch] = 1'b0; end
                        K_REP:   e_rep[sb[i].ch] = 1'b1;
                        default: exp_pressed = '0;
                    endcase
                    sb.delete(i);
                end
            end
            check("pressed",       pressed,       exp_pressed);
            check("press_pulse",   press_pulse,   e_press);
            check("release_pulse", release_pulse, e_rel);
            check("repeat_pulse",  repeat_pulse,  e_rep);
        end
    end

    initial begin
        int p, p2, p3;
        Reset     = 1'b1;
        btn_n     = '1;
        repeat_en = '0;
        tick(3);
        Reset  = 1'b0;
        mon_en = 1'b1;

        // Idle after reset.
        tick(100);

        // Channel 0 clean press and release.
        btn_n[0] = 1'b0;
        push(cyc + 1 + LAT, K_PRESS, 0);
        tick(40);
        btn_n[0] = 1'b1;
        push(cyc + 1 + LAT, K_REL, 0);
        tick(30);

        // 15-cycle glitch rejected, 16-cycle low accepted.
        btn_n[0] = 1'b0;
        tick(15);
        btn_n[0] = 1'b1;
        tick(40);
        btn_n[0] = 1'b0;
        push(cyc + 1 + LAT, K_PRESS, 0);
        tick(16);
        btn_n[0] = 1'b1;
        push(cyc + 1 + LAT, K_REL, 0);
        tick(40);

        // Channel 1 auto-repeat for a 200-cycle hold: 9 pulses.
        repeat_en[1] = 1'b1;
        btn_n[1]     = 1'b0;
        p = cyc + 1 + LAT;
        push(p, K_PRESS, 1);
        for (int k = 0; k < 9; k++) push(p + 64 + 16 * k, K_REP, 1);
        wait_until(p + 200 - 1 - LAT);
        btn_n[1] = 1'b1;
        push(cyc + 1 + LAT, K_REL, 1);
        tick(40);

        // Dropping repeat_en right after the 3rd pulse stops the train.
        btn_n[1] = 1'b0;
        p = cyc + 1 + LAT;
        push(p, K_PRESS, 1);
        for (int k = 0; k < 3; k++) push(p + 64 + 16 * k, K_REP, 1);
        wait_until(p + 96);
        repeat_en[1] = 1'b0;
        wait_until(p + 150);
        btn_n[1] = 1'b1;
        push(cyc + 1 + LAT, K_REL, 1);
        tick(40);

        // Channels 2 and 3 offset by 5 cycles; ch2 released on an expiry cycle.
        repeat_en[3:2] = 2'b11;
        btn_n[2] = 1'b0;
        p2 = cyc + 1 + LAT;
        tick(5);
        btn_n[3] = 1'b0;
        p3 = cyc + 1 + LAT;
        push(p2, K_PRESS, 2);
        push(p3, K_PRESS, 3);
        for (int k = 0; k < 2; k++) push(p2 + 64 + 16 * k, K_REP, 2);
        for (int k = 0; k < 4; k++) push(p3 + 64 + 16 * k, K_REP, 3);
        wait_until(p2 + 96 - 1 - LAT);
        btn_n[2] = 1'b1;
        push(cyc + 1 + LAT, K_REL, 2);
        wait_until(p3 + 120 - 1 - LAT);
        btn_n[3] = 1'b1;
        push(cyc + 1 + LAT, K_REL, 3);
        tick(40);
        repeat_en = '0;

        // Reset mid-hold, button still held afterwards -> fresh press.
        btn_n[0] = 1'b0;
        push(cyc + 1 + LAT, K_PRESS, 0);
        tick(30);
        Reset = 1'b1;
        push(cyc + 1, K_CLR, 0);
        tick(3);
        Reset = 1'b0;
        push(cyc + 1 + LAT, K_PRESS, 0);
        tick(25);
        btn_n[0] = 1'b1;
        push(cyc + 1 + LAT, K_REL, 0);
        tick(30);

        compared++;
        assert (sb.size() == 0) else begin
            mismatched++;
            $error("FAIL scoreboard_drain observed=%0d expected=0 pending events", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
